// File: rtl/inta_cycle_sequencer.sv
// Interrupt-acknowledge cycle generator: turns a synchronised INT request into the
// two-pulse NINTA sequence, captures the PIC vector and offers it over valid/ready.
module inta_cycle_sequencer #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 2,
    parameter int unsigned REARM_W = 3
) (
    input  logic       i_clk,
    input  logic       i_nreset,
    input  logic       i_int,
    input  logic       i_if_en,
    input  logic [7:0] i_d_in,
    output logic       o_ninta,
    output logic       o_nlock,
    output logic       o_busy,
    output logic [7:0] o_vec,
    output logic       o_vec_valid,
    input  logic       i_vec_ready
);

    localparam logic [3:0] P_LD = 4'(PULSE_W - 1);
    localparam logic [3:0] G_LD = 4'(GAP_W - 1);
    localparam logic [3:0] R_LD = 4'(REARM_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_GAP,
        S_P2,
        S_HOLD,
        S_REARM
    } state_t;

    state_t     r_state, w_state;
    logic [3:0] r_cnt, w_cnt;
    logic       r_ninta, w_ninta;
    logic       r_nlock, w_nlock;
    logic       r_busy, w_busy;
    logic [7:0] r_vec, w_vec;
    logic       r_vec_valid, w_vec_valid;
    logic       r_int_s1, r_int_s2;
    logic       w_req;
    logic       w_cnt_zero;

    assign w_req      = r_int_s2 && i_if_en && !r_vec_valid;
    assign w_cnt_zero = (r_cnt == 4'd0);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_ninta     = r_ninta;
        w_nlock     = r_nlock;
        w_busy      = r_busy;
        w_vec       = r_vec;
        w_vec_valid = r_vec_valid;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state = S_P1;
                    w_ninta = 1'b0;
                    w_nlock = 1'b0;
                    w_busy  = 1'b1;
                    w_cnt   = P_LD;
                end
            end
            // Once P1 is entered the sequence runs to completion regardless of INT/IF_EN.
            S_P1: begin
                if (w_cnt_zero) begin
                    w_state = S_GAP;
                    w_ninta = 1'b1;
                    w_cnt   = G_LD;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_GAP: begin
                if (w_cnt_zero) begin
                    w_state = S_P2;
                    w_ninta = 1'b0;
                    w_nlock = 1'b1;
                    w_cnt   = P_LD;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_P2: begin
                if (w_cnt_zero) begin
                    w_state     = S_HOLD;
                    w_ninta     = 1'b1;
                    w_vec       = i_d_in;
                    w_vec_valid = 1'b1;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (r_vec_valid && i_vec_ready) begin
                    w_state     = S_REARM;
                    w_vec_valid = 1'b0;
                    w_busy      = 1'b0;
                    w_cnt       = R_LD;
                end
            end
            S_REARM: begin
                // Last rearm cycle with a pending request goes straight to P1.
                if (w_cnt_zero) begin
                    if (w_req) begin
                        w_state = S_P1;
                        w_ninta = 1'b0;
                        w_nlock = 1'b0;
                        w_busy  = 1'b1;
                        w_cnt   = P_LD;
                    end else begin
                        w_state = S_IDLE;
                    end
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_ninta     <= 1'b1;
            r_nlock     <= 1'b1;
            r_busy      <= 1'b0;
            r_vec       <= 8'h00;
            r_vec_valid <= 1'b0;
            r_int_s1    <= 1'b0;
            r_int_s2    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_ninta     <= w_ninta;
            r_nlock     <= w_nlock;
            r_busy      <= w_busy;
            r_vec       <= w_vec;
            r_vec_valid <= w_vec_valid;
            r_int_s1    <= i_int;
            r_int_s2    <= r_int_s1;
        end
    end

    assign o_ninta     = r_ninta;
    assign o_nlock     = r_nlock;
    assign o_busy      = r_busy;
    assign o_vec       = r_vec;
    assign o_vec_valid = r_vec_valid;

endmodule

// File: tb/tb_inta_cycle_sequencer.sv
// Directed bench: default-parameter instance A plus a 1/3/1 instance B, vectors
// checked through a scoreboard queue.
module tb_inta_cycle_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_nreset, a_int, a_if_en, a_ready;
    logic [7:0] a_d;
    logic       a_ninta, a_nlock, a_busy, a_valid;
    logic [7:0] a_vec;

    logic       b_nreset, b_int, b_if_en, b_ready;
    logic [7:0] b_d;
    logic       b_ninta, b_nlock, b_busy, b_valid;
    logic [7:0] b_vec;

    inta_cycle_sequencer u_a (
        .i_clk(clk), .i_nreset(a_nreset), .i_int(a_int), .i_if_en(a_if_en),
        .i_d_in(a_d), .o_ninta(a_ninta), .o_nlock(a_nlock), .o_busy(a_busy),
        .o_vec(a_vec), .o_vec_valid(a_valid), .i_vec_ready(a_ready)
    );

    inta_cycle_sequencer #(.PULSE_W(1), .GAP_W(3), .REARM_W(1)) u_b (
        .i_clk(clk), .i_nreset(b_nreset), .i_int(b_int), .i_if_en(b_if_en),
        .i_d_in(b_d), .o_ninta(b_ninta), .o_nlock(b_nlock), .o_busy(b_busy),
        .o_vec(b_vec), .o_vec_valid(b_valid), .i_vec_ready(b_ready)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic sb_check(input string tag, input logic [7:0] obs);
        logic [7:0] exp_v;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            exp_v = sb.pop_front();
            chk(tag, 32'(obs), 32'(exp_v));
        end
    endtask

    logic exp_a_n [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_a_l [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_b_n [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        a_nreset = 1'b0; a_int = 1'b0; a_if_en = 1'b0; a_ready = 1'b0; a_d = 8'h00;
        b_nreset = 1'b0; b_int = 1'b0; b_if_en = 1'b0; b_ready = 1'b0; b_d = 8'h00;
        tick(); tick(); tick();
        chk("rst_ninta", 32'(a_ninta), 32'd1);
        chk("rst_nlock", 32'(a_nlock), 32'd1);
        chk("rst_busy",  32'(a_busy),  32'd0);
        chk("rst_vec",   32'(a_vec),   32'h00);
        chk("rst_valid", 32'(a_valid), 32'd0);
        a_nreset = 1'b1;
        tick();

        // Default sequence: synchroniser latency then 2/2/2 waveform.
        a_int = 1'b1; a_if_en = 1'b1;
        tick(); tick();
        chk("sync_not_yet", 32'(a_ninta), 32'd1);
        tick();
        for (int j = 0; j < 7; j++) begin
            chk($sformatf("seq1_ninta_%0d", j), 32'(a_ninta), 32'(exp_a_n[j]));
            chk($sformatf("seq1_nlock_%0d", j), 32'(a_nlock), 32'(exp_a_l[j]));
            if (j < 6) chk($sformatf("seq1_valid_%0d", j), 32'(a_valid), 32'd0);
            if (j == 3) begin
                a_d = 8'h4A;
                sb.push_back(8'h4A);
            end
            if (j < 6) tick();
        end
        chk("seq1_valid", 32'(a_valid), 32'd1);
        chk("seq1_busy", 32'(a_busy), 32'd1);
        sb_check("seq1_vec", a_vec);

        // Stall: vector must hold, no new acknowledge while unconsumed.
        a_d = 8'h55;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("stall_valid_%0d", k), 32'(a_valid), 32'd1);
            chk($sformatf("stall_vec_%0d", k), 32'(a_vec), 32'h4A);
            chk($sformatf("stall_ninta_%0d", k), 32'(a_ninta), 32'd1);
        end
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        chk("acc_valid", 32'(a_valid), 32'd0);
        chk("acc_busy", 32'(a_busy), 32'd0);
        chk("acc_vec_kept", 32'(a_vec), 32'h4A);
        chk("rearm0_ninta", 32'(a_ninta), 32'd1);
        tick();
        chk("rearm1_ninta", 32'(a_ninta), 32'd1);
        tick();
        chk("rearm2_ninta", 32'(a_ninta), 32'd1);
        tick();
        chk("seq2_start", 32'(a_ninta), 32'd0);
        chk("seq2_busy", 32'(a_busy), 32'd1);

        // INT dropped during GAP: second pulse still issued.
        tick();
        chk("seq2_p1b", 32'(a_ninta), 32'd0);
        tick();
        chk("seq2_gap", 32'(a_ninta), 32'd1);
        a_int = 1'b0; a_d = 8'h3F;
        sb.push_back(8'h3F);
        tick();
        tick();
        chk("seq2_p2", 32'(a_ninta), 32'd0);
        tick();
        tick();
        chk("seq2_valid", 32'(a_valid), 32'd1);
        sb_check("seq2_vec", a_vec);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        chk("seq2_acc", 32'(a_valid), 32'd0);

        // IF_EN gating.
        a_if_en = 1'b0; a_int = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("ifen_ninta_%0d", k), 32'(a_ninta), 32'd1);
            chk($sformatf("ifen_busy_%0d", k), 32'(a_busy), 32'd0);
        end
        a_if_en = 1'b1;
        tick();
        chk("ifen_start", 32'(a_ninta), 32'd0);
        chk("ifen_busy", 32'(a_busy), 32'd1);

        // Reset in second P1 cycle aborts the sequence.
        tick();
        chk("abort_p1b", 32'(a_ninta), 32'd0);
        a_nreset = 1'b0;
        tick();
        chk("abort_ninta", 32'(a_ninta), 32'd1);
        chk("abort_nlock", 32'(a_nlock), 32'd1);
        chk("abort_busy",  32'(a_busy),  32'd0);
        chk("abort_valid", 32'(a_valid), 32'd0);
        chk("abort_vec",   32'(a_vec),   32'h00);
        a_int = 1'b0; a_if_en = 1'b0; a_nreset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("post_abort_ninta_%0d", k), 32'(a_ninta), 32'd1);
            chk($sformatf("post_abort_nlock_%0d", k), 32'(a_nlock), 32'd1);
        end

        // Instance B: 1/3/1 timing, back-to-back sequences under sustained INT.
        b_nreset = 1'b1; b_int = 1'b1; b_if_en = 1'b1; b_ready = 1'b1;
        for (int n = 0; n < 10 && b_ninta !== 1'b0; n++) tick();
        chk("b_start", 32'(b_ninta), 32'd0);
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < 7; j++) begin
                chk($sformatf("b%0d_ninta_%0d", s, j), 32'(b_ninta), 32'(exp_b_n[j]));
                if (j == 0) begin
                    b_d = 8'hA0 + 8'(s);
                    sb.push_back(8'hA0 + 8'(s));
                end
                if (j == 5) begin
                    chk($sformatf("b%0d_valid", s), 32'(b_valid), 32'd1);
                    sb_check($sformatf("b%0d_vec", s), b_vec);
                end else begin
                    chk($sformatf("b%0d_novalid_%0d", s, j), 32'(b_valid), 32'd0);
                end
                tick();
            end
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
